// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller with 16-byte lines.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise both count outputs are tied to 0.
module dcache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_re,
  input  logic [3:0]   cpu_we,
  input  logic [31:0]  cpu_din,
  output logic [31:0]  cpu_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rnw,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_rdata_valid,
  input  logic [127:0] mem_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_REQ  = 2'd1,
    RF_REQ  = 2'd2,
    RF_WAIT = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [127:0]          data_r [LINES];
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [LINES-1:0]      valid_r, dirty_r;

  logic [1:0]            offset_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [127:0]          line_s;
  logic                  is_write_s, req_s, hit_s;
  logic                  hit_ev_s, miss_ev_s, install_s;
  logic                  unused_s;

  function automatic logic [127:0] merge_line(input logic [127:0] line, input logic [1:0] off,
                                              input logic [3:0] we, input logic [31:0] din);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        res[int'(off) * 32 + b * 8 +: 8] = din[b * 8 +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] off);
    return line[int'(off) * 32 +: 32];
  endfunction

  assign offset_s   = cpu_addr[3:2];
  assign index_s    = cpu_addr[INDEX_BITS+3:4];
  assign tag_s      = cpu_addr[31:INDEX_BITS+4];
  assign line_s     = data_r[index_s];
  assign is_write_s = (cpu_we != 4'b0000);
  assign req_s      = cpu_re || is_write_s;
  assign hit_s      = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign hit_ev_s   = (state_r == IDLE) && req_s && hit_s;
  assign miss_ev_s  = (state_r == IDLE) && req_s && !hit_s;
  assign install_s  = (state_r == RF_WAIT) && mem_rdata_valid;
  assign unused_s   = &{1'b0, cpu_addr[1:0]};

  // Next-state and memory-side outputs; stall is combinational so a miss freezes the CPU at once.
  always_comb begin
    state_next_s  = state_r;
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b0;
    mem_req_addr  = 32'd0;
    mem_wdata     = 128'd0;
    case (state_r)
      IDLE: begin
        stall = miss_ev_s;
        if (miss_ev_s) begin
          if (valid_r[index_s] && dirty_r[index_s]) begin
            state_next_s = WB_REQ;
          end else begin
            state_next_s = RF_REQ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b0;
        mem_req_addr  = {tag_r[index_s], index_s, 4'b0000};
        mem_wdata     = line_s;
        if (mem_req_ready) begin
          state_next_s = RF_REQ;
        end else begin
          state_next_s = WB_REQ;
        end
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b1;
        mem_req_addr  = {cpu_addr[31:4], 4'b0000};
        if (mem_req_ready) begin
          state_next_s = RF_WAIT;
        end else begin
          state_next_s = RF_REQ;
        end
      end
      RF_WAIT: begin
        if (mem_rdata_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RF_WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cpu_dout <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (hit_ev_s && !is_write_s) begin
        cpu_dout <= word_of(line_s, offset_s);
      end
    end
  end

  // Line status: a writeback cleans the victim, a refill installs a clean valid line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else begin
      if (hit_ev_s && is_write_s) begin
        dirty_r[index_s] <= 1'b1;
      end
      if ((state_r == WB_REQ) && mem_req_ready) begin
        dirty_r[index_s] <= 1'b0;
      end
      if (install_s) begin
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b0;
      end
    end
  end

  // Data and tag storage; left unreset since valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (install_s) begin
        data_r[index_s] <= mem_rdata;
        tag_r[index_s]  <= tag_s;
      end else if (hit_ev_s && is_write_s) begin
        data_r[index_s] <= merge_line(line_s, offset_s, cpu_we, cpu_din);
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;
  logic        replay_r;

  // The first IDLE cycle after a refill replays the held miss, so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
      replay_r   <= 1'b0;
    end else begin
      replay_r <= install_s;
      if (hit_ev_s && !replay_r) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_ev_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: flat golden memory plus per-index residency model, randomized accesses
// with a responding memory, directed literal checks, and a per-cycle request-stability monitor.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr;
  logic         cpu_re;
  logic [3:0]   cpu_we;
  logic [31:0]  cpu_din;
  logic [31:0]  cpu_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rnw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_wdata;
  logic         mem_rdata_valid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .stall(stall), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Model state: backing memory, architectural (golden) memory, and line residency per index.
  bit [31:0]  back_mem [bit [29:0]];
  bit [31:0]  gold_mem [bit [29:0]];
  bit         rv [64];
  bit         rd [64];
  bit [21:0]  rt [64];
  int         m_hits = 0;
  int         m_misses = 0;
  logic [31:0] exp_dout = 32'd0;

  logic [31:0]  last_wb_addr, last_rf_addr, last_dout;
  logic [127:0] last_wb_data;
  int           last_stalls;

  function automatic bit [31:0] def_word(input bit [29:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic bit [31:0] back_rd(input bit [29:0] wa);
    return back_mem.exists(wa) ? back_mem[wa] : def_word(wa);
  endfunction

  function automatic bit [31:0] gold_rd(input bit [29:0] wa);
    return gold_mem.exists(wa) ? gold_mem[wa] : back_rd(wa);
  endfunction

  function automatic bit [127:0] gold_line(input bit [27:0] la);
    return {gold_rd({la, 2'd3}), gold_rd({la, 2'd2}), gold_rd({la, 2'd1}), gold_rd({la, 2'd0})};
  endfunction

  function automatic bit [127:0] back_line(input bit [27:0] la);
    return {back_rd({la, 2'd3}), back_rd({la, 2'd2}), back_rd({la, 2'd1}), back_rd({la, 2'd0})};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_counts();
    int eh, em;
`ifdef DCACHE_STATS_EN
    eh = m_hits;
    em = m_misses;
`else
    eh = 0;
    em = 0;
`endif
    chk("hit_count", 128'(hit_count), 128'(eh));
    chk("miss_count", 128'(miss_count), 128'(em));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      rv[i] = 1'b0;
      rd[i] = 1'b0;
    end
    gold_mem.delete();
    m_hits = 0;
    m_misses = 0;
    exp_dout = 32'd0;
  endtask

  // One CPU access; the bench plays memory with the given ready/data delays. abort resets in RF_WAIT.
  task automatic access(input logic [31:0] addr, input logic re, input logic [3:0] we,
                        input logic [31:0] din, input int dwb, input int drf, input int ddat,
                        input bit abort);
    bit [29:0] wa;
    int        idx, phase, cnt, stalls, exp_stalls;
    bit [21:0] tg;
    bit        wr, hit, exp_wb, done, junk;
    logic [31:0] exp_a;
    bit [31:0] w;
    wa  = addr[31:2];
    idx = int'(addr[9:4]);
    tg  = addr[31:10];
    wr  = (we != 4'b0000);
    hit = rv[idx] && (rt[idx] == tg);
    exp_wb = !hit && rv[idx] && rd[idx];
    junk = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_re = re; cpu_we = we; cpu_din = din;
    @(negedge clk);
    chk("stall_on_entry", 128'(stall), 128'(!hit));
    if (hit) m_hits++; else m_misses++;
    stalls = hit ? 0 : 1;
    if (hit && junk) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    if (!hit) begin
      phase = exp_wb ? 0 : 1;
      cnt   = exp_wb ? dwb : drf;
      done  = 1'b0;
      exp_stalls = 1 + (exp_wb ? dwb + 1 : 0) + drf + 1 + ddat + 1;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
        @(negedge clk);
        if (mem_req_ready) begin
          mem_req_ready = 1'b0;
          if (phase == 0) begin phase = 1; cnt = drf; end
          else begin phase = 2; cnt = ddat; end
        end
        if (mem_rdata_valid) begin
          mem_rdata_valid = 1'b0;
          phase = 3;
        end
        if (phase == 3) begin
          chk("stall_release", 128'(stall), 128'(0));
          done = 1'b1;
        end else begin
          chk("stall_in_miss", 128'(stall), 128'(1));
          stalls++;
          if (phase == 0) begin
            exp_a = {rt[idx], addr[9:4], 4'b0000};
            chk("wb_valid", 128'(mem_req_valid), 128'(1));
            chk("wb_rnw", 128'(mem_req_rnw), 128'(0));
            chk("wb_addr", 128'(mem_req_addr), 128'(exp_a));
            chk("wb_data", mem_wdata, gold_line(exp_a[31:4]));
            last_wb_addr = mem_req_addr;
            last_wb_data = mem_wdata;
            if (cnt == 0) begin
              mem_req_ready = 1'b1;
              for (int k = 0; k < 4; k++) back_mem[{exp_a[31:4], 2'(k)}] = mem_wdata[k*32 +: 32];
            end else cnt--;
          end else if (phase == 1) begin
            chk("rf_valid", 128'(mem_req_valid), 128'(1));
            chk("rf_rnw", 128'(mem_req_rnw), 128'(1));
            chk("rf_addr", 128'(mem_req_addr), 128'({addr[31:4], 4'b0000}));
            last_rf_addr = mem_req_addr;
            if (cnt == 0) mem_req_ready = 1'b1; else cnt--;
          end else begin
            chk("rf_wait_bus_idle", 128'(mem_req_valid), 128'(0));
            if (abort) begin
              rst = 1'b1; cpu_re = 1'b0; cpu_we = 4'b0000;
              @(negedge clk);
              rst = 1'b0;
              mem_rdata_valid = 1'b1;
              mem_rdata = back_line(addr[31:4]);
              @(negedge clk);
              mem_rdata_valid = 1'b0;
              model_reset();
              chk("abort_stall", 128'(stall), 128'(0));
              chk("abort_req_valid", 128'(mem_req_valid), 128'(0));
              chk("abort_dout", 128'(cpu_dout), 128'(0));
              chk_counts();
              return;
            end
            if (cnt == 0) begin
              mem_rdata_valid = 1'b1;
              mem_rdata = back_line(addr[31:4]);
            end else cnt--;
          end
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL miss_timeout: got no stall release, expected one within 300 cycles");
      end
      chk("stall_cycles", 128'(stalls), 128'(exp_stalls));
      rv[idx] = 1'b1; rt[idx] = tg; rd[idx] = 1'b0;
    end
    last_stalls = stalls;
    @(posedge clk); #1;
    mem_rdata_valid = 1'b0;
    if (wr) begin
      w = gold_rd(wa);
      for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = din[b*8 +: 8];
      gold_mem[wa] = w;
      rd[idx] = 1'b1;
      chk("write_keeps_dout", 128'(cpu_dout), 128'(exp_dout));
    end else begin
      exp_dout = gold_rd(wa);
      chk("read_data", 128'(cpu_dout), 128'(exp_dout));
    end
    last_dout = cpu_dout;
    cpu_re = 1'b0; cpu_we = 4'b0000;
    chk_counts();
  endtask

  // Per-cycle monitor: a pending request must hold steady, and any request implies stall.
  logic         acc_q = 1'b0;
  logic         rst_q = 1'b1;
  logic         pv = 1'b0;
  logic         prnw = 1'b0;
  logic [31:0]  pa = 32'd0;
  logic [127:0] pd = 128'd0;
  always @(posedge clk) begin
    acc_q <= mem_req_valid & mem_req_ready;
    rst_q <= rst;
  end
  always @(negedge clk) begin
    if (pv === 1'b1 && !acc_q && !rst_q) begin
      chk("req_hold_valid", 128'(mem_req_valid), 128'(1));
      chk("req_hold_addr", 128'({mem_req_rnw, mem_req_addr}), 128'({prnw, pa}));
      chk("req_hold_data", mem_wdata, pd);
    end
    if (mem_req_valid === 1'b1) begin
      chk("req_implies_stall", 128'(stall), 128'(1));
      chk("req_addr_aligned", 128'(mem_req_addr[3:0]), 128'(0));
    end
    pv   <= mem_req_valid;
    prnw <= mem_req_rnw;
    pa   <= mem_req_addr;
    pd   <= mem_wdata;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected one before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  we;
    logic        re;
    int          t;
    rst = 1'b1; cpu_addr = 32'd0; cpu_re = 1'b0; cpu_we = 4'b0000; cpu_din = 32'd0;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = 128'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", 128'(cpu_dout), 128'(0));
    chk("reset_stall", 128'(stall), 128'(0));
    chk("reset_req_valid", 128'(mem_req_valid), 128'(0));
    chk_counts();

    back_mem[30'h40] = 32'h11111111; back_mem[30'h41] = 32'h22222222;
    back_mem[30'h42] = 32'h33333333; back_mem[30'h43] = 32'h44444444;
    access(32'h0000_0104, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b0);
    chk("lit_miss_dout", 128'(last_dout), 128'(32'h22222222));
    chk("lit_miss_stalls", 128'(last_stalls), 128'(3));
    chk("lit_miss_rf_addr", 128'(last_rf_addr), 128'(32'h0000_0100));
    access(32'h0000_0104, 1'b0, 4'b0011, 32'hAABBCCDD, 0, 0, 0, 1'b0);
    chk("lit_write_hit_stalls", 128'(last_stalls), 128'(0));
    access(32'h0000_0104, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b0);
    chk("lit_merged_dout", 128'(last_dout), 128'(32'h2222CCDD));
    access(32'h0000_0504, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b0);
    chk("lit_wb_addr", 128'(last_wb_addr), 128'(32'h0000_0100));
    chk("lit_wb_word1", 128'(last_wb_data[63:32]), 128'(32'h2222CCDD));
    chk("lit_rf_addr_500", 128'(last_rf_addr), 128'(32'h0000_0500));
    access(32'h0000_0504, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("lit_hits", 128'(hit_count), 128'(3));
    chk("lit_misses", 128'(miss_count), 128'(2));
`else
    chk("lit_hits", 128'(hit_count), 128'(0));
    chk("lit_misses", 128'(miss_count), 128'(0));
`endif
    access(32'h0000_0508, 1'b1, 4'b1111, 32'h0BAD_F00D, 0, 0, 0, 1'b0);
    access(32'h0000_0A00, 1'b1, 4'b0000, 32'd0, 0, 5, 0, 1'b0);
    chk("lit_ready_hold_stalls", 128'(last_stalls), 128'(8));
    access(32'h0000_0C40, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b1);
    access(32'h0000_0C40, 1'b1, 4'b0000, 32'd0, 0, 0, 0, 1'b0);
    chk("lit_rereads_miss", 128'(last_stalls), 128'(3));

    for (int n = 0; n < 400; n++) begin
      t  = $urandom_range(0, 3);
      a  = {(t == 3) ? 22'h3FFFFF : 22'(t), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3))};
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      re = (we == 4'b0000) ? 1'b1 : 1'($urandom_range(0, 1));
      access(a, re, we, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: INDEX_BITS, default 6, log2 of line count (64 lines x 16 B = 1 KiB).
REQ-002 Port: clk  in  1  clock.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: cpu_addr  in  32  byte address from CPU; bits [1:0] ignored.
REQ-005 Port: cpu_re  in  1  read request.
REQ-006 Port: cpu_we  in  4  byte write enables; nonzero means write.
REQ-007 Port: cpu_din  in  32  write data, already byte-lane aligned.
REQ-008 Port: cpu_dout  out  32  read data, registered.
REQ-009 Port: stall  out  1  freeze CPU pipeline.
REQ-010 Port: mem_req_valid  out  1  memory request valid.
REQ-011 Port: mem_req_ready  in  1  memory accepts request.
REQ-012 Port: mem_req_rnw  out  1  1 = line read, 0 = line write.
REQ-013 Port: mem_req_addr  out  32  line-aligned address; bits [3:0] = 0.
REQ-014 Port: mem_wdata  out  128  victim line for writeback.
REQ-015 Port: mem_rdata_valid  in  1  refill data valid, one-cycle pulse.
REQ-016 Port: mem_rdata  in  128  refill line; word 0 in bits [31:0].
REQ-017 Port: hit_count  out  32  read/write hit counter.
REQ-018 Port: miss_count  out  32  miss counter.

Function
REQ-019 Cache organisation SHALL be direct-mapped, write-back, write-allocate, 16-byte lines: offset = addr[3:2], index = addr[INDEX_BITS+3:4], tag = addr[31:INDEX_BITS+4]; each line has valid and dirty bits.
REQ-020 FSM states SHALL be IDLE, WB_REQ, RF_REQ, RF_WAIT.
REQ-021 IDLE, request (cpu_re or cpu_we != 0) with valid and tag match (hit): read SHALL drive cpu_dout with the addressed word on the next edge; write SHALL merge the enabled bytes and set dirty on the same edge; stall = 0.
REQ-022 When cpu_we != 0 and cpu_re = 1, the access SHALL be treated as a write only.
REQ-023 IDLE miss: stall SHALL assert combinationally in the same cycle; next state SHALL be WB_REQ if the victim is valid and dirty, otherwise RF_REQ.
REQ-024 WB_REQ: mem_req_valid = 1, rnw = 0, addr = {victim tag, index, 4'b0}, mem_wdata = victim line; on mem_req_ready, clear dirty and go to RF_REQ.
REQ-025 RF_REQ: mem_req_valid = 1, rnw = 1, addr = {cpu_addr[31:4], 4'b0}; on mem_req_ready, go to RF_WAIT.
REQ-026 RF_WAIT: on mem_rdata_valid, install the line with valid = 1, dirty = 0, new tag, and return to IDLE; the held request then re-hits in IDLE.
REQ-027 stall SHALL be 1 in every non-IDLE state; the CPU holds the cpu_* inputs stable while stall = 1.
REQ-028 mem_req_valid, once raised, SHALL remain high with stable addr/data until mem_req_ready is sampled high.
REQ-029 mem_rdata_valid SHALL be ignored outside RF_WAIT.
REQ-030 Minimum clean-miss penalty SHALL be 3 stall cycles (RF_REQ with ready = 1, RF_WAIT, hit in IDLE); stall SHALL deassert in the cycle after mem_rdata_valid.
REQ-031 With no request in IDLE, cpu_dout SHALL hold its last value.

Reset
REQ-032 On rst: state = IDLE, all valid and dirty bits = 0, cpu_dout = 0, mem_req_valid = 0, hit_count = 0, miss_count = 0.
REQ-033 rst asserted mid-miss SHALL abandon the transaction with no line install and no dirty writeback.

Configuration
REQ-034 Macro DCACHE_STATS_EN: when defined, hit_count increments once per hit in IDLE and miss_count once per miss entry (IDLE to WB_REQ or RF_REQ), both wrapping at 2^32; when undefined, both outputs SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-035 After reset, read 0x00000104 with memory returning line 0x44444444_33333333_22222222_11111111 -> stall for 3 cycles, cpu_dout = 0x22222222, one RF request at 0x00000100.
REQ-036 Write 0xAABBCCDD, we = 4'b0011, to 0x00000104 (hit) -> no stall; a subsequent read returns 0x2222CCDD.
REQ-037 Read 0x00000504 (same index, dirty victim) -> WB request at 0x00000100 containing 0x2222CCDD, then RF request at 0x00000500.
REQ-038 Hold mem_req_ready = 0 for 5 cycles in RF_REQ -> mem_req_valid and mem_req_addr remain stable and stall stays high throughout.
REQ-039 Assert rst in RF_WAIT, then apply a late mem_rdata_valid -> state = IDLE, data ignored, and a re-read of the same address misses again.
REQ-040 With DCACHE_STATS_EN defined, run 3 hits and 2 misses -> hit_count = 3, miss_count = 2; with it undefined, both counts = 0.
